// File: rtl/prog_counter_ctl.sv
// prog_counter_ctl: program counter for Richie Jr with hold, absolute jump,
// PC-relative branch and a hardware call/return stack. The PC, stack depth
// counter and sticky error flag are registered. The full/empty flags are
// decoded from the depth counter.
module prog_counter_ctl #(
    parameter int AW                = 4,
    parameter int OW                = 4,
    parameter int DEPTH             = 4,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         en,
    input  logic                         ld,
    input  logic [AW-1:0]                ld_addr,
    input  logic                         br,
    input  logic [OW-1:0]                br_off,
    input  logic                         call,
    input  logic                         ret,
    output logic [AW-1:0]                pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   stk_cnt,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         stk_err
);

    // Counter width covers 0..DEPTH, index width covers 0..DEPTH-1.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The single action taken on an enabled edge, already resolved by priority.
    typedef enum logic [3:0] {
        ACT_HOLD,
        ACT_BOTH_ERR,
        ACT_RET,
        ACT_RET_ERR,
        ACT_CALL,
        ACT_CALL_ERR,
        ACT_LOAD,
        ACT_BRANCH,
        ACT_INC
    } action_t;

    action_t         action;
    logic [AW-1:0]   pc_plus_one;
    logic [AW-1:0]   br_target;
    logic [AW-1:0]   stack_top;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   pop_idx;
    logic [AW-1:0]   stack_mem [DEPTH];

    // Sequential successor and branch target; both wrap modulo 2^AW naturally.
    assign pc_plus_one = pc_out + AW'(1);
    assign br_target   = pc_out + AW'($signed(br_off));

    // The next free slot is at stk_cnt, the top of stack one below it.
    assign push_idx  = IW'(stk_cnt);
    assign pop_idx   = IW'(stk_cnt - CW'(1));
    assign stack_top = stack_mem[pop_idx];

    assign stk_full  = (stk_cnt == CW'(DEPTH));
    assign stk_empty = (stk_cnt == '0);

    // Resolve the request lines into exactly one action using the fixed priority.
    always_comb begin
        action = ACT_HOLD;
        if (en) begin
            if (call && ret) begin
                action = ACT_BOTH_ERR;
            end else if (ret) begin
                action = stk_empty ? ACT_RET_ERR : ACT_RET;
            end else if (call) begin
                action = stk_full ? ACT_CALL_ERR : ACT_CALL;
            end else if (ld) begin
                action = ACT_LOAD;
            end else if (br) begin
                action = ACT_BRANCH;
            end else begin
                action = ACT_INC;
            end
        end
    end

    // Update PC, stack depth and sticky error; reset discards the whole stack.
    always_ff @(posedge clk) begin
        if (res) begin
            pc_out  <= RST_VEC;
            stk_cnt <= '0;
            stk_err <= 1'b0;
        end else begin
            case (action)
                ACT_BOTH_ERR, ACT_RET_ERR, ACT_CALL_ERR: begin
                    stk_err <= 1'b1;
                    pc_out  <= pc_plus_one;
                end
                ACT_RET: begin
                    pc_out  <= stack_top;
                    stk_cnt <= stk_cnt - CW'(1);
                end
                ACT_CALL: begin
                    pc_out  <= ld_addr;
                    stk_cnt <= stk_cnt + CW'(1);
                end
                ACT_LOAD:   pc_out <= ld_addr;
                ACT_BRANCH: pc_out <= br_target;
                ACT_INC:    pc_out <= pc_plus_one;
                default:    pc_out <= pc_out;
            endcase
        end
    end

    // Store the return address on a successful call; contents need no reset.
    always_ff @(posedge clk) begin
        if (!res && (action == ACT_CALL)) begin
            stack_mem[push_idx] <= pc_plus_one;
        end
    end

endmodule

// File: tb/tb_prog_counter_ctl.sv
// tb_prog_counter_ctl: scoreboard bench for prog_counter_ctl. A stimulus
// process drives requests and pushes the reference model's expected state;
// a monitor pops and compares after every clock edge.
module tb_prog_counter_ctl;

    localparam int AW      = 4;
    localparam int OW      = 4;
    localparam int DEPTH   = 4;
    localparam int RST_VEC = 0;
    localparam int MODV    = 1 << AW;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk;
    logic          res;
    logic          en;
    logic          ld;
    logic [AW-1:0] ld_addr;
    logic          br;
    logic [OW-1:0] br_off;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc_out;
    logic [CW-1:0] stk_cnt;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;

    typedef struct {
        int pc;
        int cnt;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: PC as an integer, the return stack as a queue.
    int   m_pc = 0;
    int   m_stack[$];
    bit   m_err = 0;

    prog_counter_ctl #(
        .AW(AW), .OW(OW), .DEPTH(DEPTH), .RST_VEC(AW'(RST_VEC))
    ) dut (
        .clk(clk), .res(res), .en(en), .ld(ld), .ld_addr(ld_addr),
        .br(br), .br_off(br_off), .call(call), .ret(ret),
        .pc_out(pc_out), .stk_cnt(stk_cnt), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and predict the result.
    task automatic applyStimulus(input bit r, input bit e, input bit l, input int la,
                                 input bit b, input int bo, input bit c, input bit rt);
        exp_t x;
        int   off;
        @(negedge clk);
        res = r; en = e; ld = l; ld_addr = AW'(la); br = b; br_off = OW'(bo);
        call = c; ret = rt;
        if (r) begin
            m_pc = RST_VEC;
            m_stack.delete();
            m_err = 0;
        end else if (e) begin
            if (c && rt) begin
                m_err = 1;
                m_pc = (m_pc + 1) % MODV;
            end else if (rt) begin
                if (m_stack.size() == 0) begin
                    m_err = 1;
                    m_pc = (m_pc + 1) % MODV;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (c) begin
                if (m_stack.size() == DEPTH) begin
                    m_err = 1;
                    m_pc = (m_pc + 1) % MODV;
                end else begin
                    m_stack.push_back((m_pc + 1) % MODV);
                    m_pc = la % MODV;
                end
            end else if (l) begin
                m_pc = la % MODV;
            end else if (b) begin
                off = bo % (1 << OW);
                if (off >= (1 << (OW - 1))) off = off - (1 << OW);
                m_pc = (((m_pc + off) % MODV) + MODV) % MODV;
            end else begin
                m_pc = (m_pc + 1) % MODV;
            end
        end
        x.pc  = m_pc;
        x.cnt = m_stack.size();
        x.err = m_err;
        exp_q.push_back(x);
    endtask

    // Compare every observable output against one expected entry.
    task automatic checkOutput(input exp_t x);
        logic [AW-1:0] epc;
        logic [CW-1:0] ecnt;
        logic          efull;
        logic          eempty;
        epc    = x.pc[AW-1:0];
        ecnt   = x.cnt[CW-1:0];
        efull  = (x.cnt == DEPTH);
        eempty = (x.cnt == 0);
        checks += 5;
        if (pc_out !== epc) begin
            errors++;
            $display("[TB] FAIL pc_out: got %0d expected %0d at %0t", pc_out, epc, $time);
        end
        if (stk_cnt !== ecnt) begin
            errors++;
            $display("[TB] FAIL stk_cnt: got %0d expected %0d at %0t", stk_cnt, ecnt, $time);
        end
        if (stk_err !== x.err) begin
            errors++;
            $display("[TB] FAIL stk_err: got %0b expected %0b at %0t", stk_err, x.err, $time);
        end
        if (stk_full !== efull) begin
            errors++;
            $display("[TB] FAIL stk_full: got %0b expected %0b at %0t", stk_full, efull, $time);
        end
        if (stk_empty !== eempty) begin
            errors++;
            $display("[TB] FAIL stk_empty: got %0b expected %0b at %0t", stk_empty, eempty, $time);
        end
    endtask

    // Monitor: after each rising edge, check the state against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput(x);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        int la, bo;
        bit r, e, l, b, c, rt;
        res = 1'b1; en = 1'b0; ld = 1'b0; ld_addr = '0; br = 1'b0; br_off = '0;
        call = 1'b0; ret = 1'b0;

        $display("[TB] reset and free-running wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] relative branches");
        applyStimulus(0, 1, 1, 5, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 4'b1110, 0, 0);
        applyStimulus(0, 1, 1, 14, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 3, 0, 0);

        $display("[TB] call and return");
        applyStimulus(0, 1, 1, 2, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 9, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);

        $display("[TB] stack overflow");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 3 * i + 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);

        $display("[TB] underflow and simultaneous call/return");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 7, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 12, 0, 0, 1, 1);

        $display("[TB] enable hold and reset mid-stack");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 11, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 4, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 8, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 5, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(63) == 0);
            e  = ($urandom_range(7) != 0);
            c  = ($urandom_range(5) == 0);
            rt = ($urandom_range(5) == 0);
            l  = ($urandom_range(5) == 0);
            b  = ($urandom_range(3) == 0);
            la = $urandom_range(MODV - 1);
            bo = $urandom_range((1 << OW) - 1);
            applyStimulus(r, e, l, la, b, bo, c, rt);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
